// File: rtl/trigger_resolution_arbiter.sv
// Picks one triggered instruction per cycle (fixed lowest-index or round-robin) and holds it for the issue stage.
// Latency: 1 cycle from trigger_states to the registered selection; outputs are purely registered.
// Backpressure: selection holds while issue_ready is low; stall_alarm flags STALL_LIMIT consecutive stalled cycles.
module trigger_resolution_arbiter #(
    parameter int NUM_INSTRUCTIONS = 16,
    parameter int INDEX_WIDTH      = $clog2(NUM_INSTRUCTIONS),
    parameter int STALL_LIMIT      = 8,
    parameter int COUNT_WIDTH      = 16
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        mode,
    input  logic                        flush,
    input  logic [NUM_INSTRUCTIONS-1:0] trigger_states,
    input  logic                        issue_ready,
    output logic                        triggered_instruction_valid,
    output logic [INDEX_WIDTH-1:0]      triggered_instruction_index,
    output logic                        stall_alarm,
    output logic [COUNT_WIDTH-1:0]      issue_count
);

    localparam int STALL_WIDTH = $clog2(STALL_LIMIT + 1);
    localparam logic [STALL_WIDTH-1:0] STALL_MAX = STALL_WIDTH'(STALL_LIMIT);

    logic                   valid_q;
    logic [INDEX_WIDTH-1:0] index_q;
    logic [INDEX_WIDTH-1:0] rr_pointer;
    logic [STALL_WIDTH-1:0] stall_cnt;
    logic [COUNT_WIDTH-1:0] issue_count_q;

    logic                   accept;
    logic                   load;
    logic                   any_trigger;
    logic [INDEX_WIDTH-1:0] eff_ptr;
    logic [INDEX_WIDTH-1:0] fixed_sel;
    logic [INDEX_WIDTH-1:0] rr_sel;
    logic [INDEX_WIDTH-1:0] sel;

    assign accept      = valid_q & issue_ready;
    assign load        = ~valid_q | issue_ready;
    assign any_trigger = |trigger_states;

    // The slot just accepted is skipped next time, so the search starts one past it.
    always_comb begin
        eff_ptr = rr_pointer;
        if (accept) begin
            if (int'(index_q) == NUM_INSTRUCTIONS - 1) begin
                eff_ptr = '0;
            end else begin
                eff_ptr = index_q + 1'b1;
            end
        end
    end

    // Scanning downward lets the lowest qualifying index overwrite the others.
    always_comb begin
        fixed_sel = '0;
        for (int i = NUM_INSTRUCTIONS - 1; i >= 0; i--) begin
            logic [INDEX_WIDTH-1:0] ib;
            ib = i[INDEX_WIDTH-1:0];
            if (trigger_states[ib]) begin
                fixed_sel = ib;
            end
        end
    end

    always_comb begin
        rr_sel = '0;
        for (int k = NUM_INSTRUCTIONS - 1; k >= 0; k--) begin
            int                     idx;
            logic [INDEX_WIDTH-1:0] ib;
            idx = int'(eff_ptr) + k;
            if (idx >= NUM_INSTRUCTIONS) begin
                idx = idx - NUM_INSTRUCTIONS;
            end
            ib = idx[INDEX_WIDTH-1:0];
            if (trigger_states[ib]) begin
                rr_sel = ib;
            end
        end
    end

    assign sel = mode ? rr_sel : fixed_sel;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q       <= 1'b0;
            index_q       <= '0;
            rr_pointer    <= '0;
            stall_cnt     <= '0;
            issue_count_q <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
                index_q <= '0;
            end else if (load) begin
                valid_q <= any_trigger;
                index_q <= any_trigger ? sel : '0;
            end

            // A completed handshake counts even when a flush lands in the same cycle.
            if (accept) begin
                rr_pointer    <= eff_ptr;
                issue_count_q <= issue_count_q + 1'b1;
            end

            if (flush || accept || !valid_q) begin
                stall_cnt <= '0;
            end else if (stall_cnt != STALL_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    assign triggered_instruction_valid = valid_q;
    assign triggered_instruction_index = index_q;
    assign stall_alarm                 = (stall_cnt == STALL_MAX);
    assign issue_count                 = issue_count_q;

endmodule

// File: tb/tb_trigger_resolution_arbiter.sv
// Randomized and directed checks of trigger_resolution_arbiter against a behavioural model.
module tb_trigger_resolution_arbiter;

    localparam int N  = 16;
    localparam int IW = 4;
    localparam int SL = 8;
    localparam int CW = 16;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          mode;
    logic          flush;
    logic [N-1:0]  trigger_states;
    logic          issue_ready;
    logic          tiv;
    logic [IW-1:0] tii;
    logic          stall_alarm;
    logic [CW-1:0] issue_count;

    logic          mode5;
    logic          flush5;
    logic [4:0]    trig5;
    logic          rdy5;
    logic          tiv5;
    logic [2:0]    tii5;
    logic          alarm5;
    logic [CW-1:0] count5;

    int tests_run    = 0;
    int tests_failed = 0;

    int m_valid, m_index, m_ptr, m_stall, m_count;

    always #5 clock = ~clock;

    trigger_resolution_arbiter #(
        .NUM_INSTRUCTIONS(N), .INDEX_WIDTH(IW), .STALL_LIMIT(SL), .COUNT_WIDTH(CW)
    ) dut (
        .clock(clock), .reset_n(reset_n), .mode(mode), .flush(flush),
        .trigger_states(trigger_states), .issue_ready(issue_ready),
        .triggered_instruction_valid(tiv), .triggered_instruction_index(tii),
        .stall_alarm(stall_alarm), .issue_count(issue_count)
    );

    trigger_resolution_arbiter #(
        .NUM_INSTRUCTIONS(5), .INDEX_WIDTH(3), .STALL_LIMIT(SL), .COUNT_WIDTH(CW)
    ) dut5 (
        .clock(clock), .reset_n(reset_n), .mode(mode5), .flush(flush5),
        .trigger_states(trig5), .issue_ready(rdy5),
        .triggered_instruction_valid(tiv5), .triggered_instruction_index(tii5),
        .stall_alarm(alarm5), .issue_count(count5)
    );

    task automatic check(input string tag, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // First set slot at or after start, walking modulo N; -1 if none.
    function automatic int find_from(input logic [N-1:0] t, input int start);
        for (int k = 0; k < N; k++) begin
            if (t[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_index = 0; m_ptr = 0; m_stall = 0; m_count = 0;
    endtask

    task automatic model_edge();
        bit accept, load;
        int eff, pick;
        accept = (m_valid != 0) && issue_ready;
        load   = (m_valid == 0) || issue_ready;
        eff    = accept ? (m_index + 1) % N : m_ptr;
        pick   = mode ? find_from(trigger_states, eff) : find_from(trigger_states, 0);
        if (flush || accept || m_valid == 0) m_stall = 0;
        else if (m_stall < SL) m_stall++;
        if (accept) begin
            m_ptr   = eff;
            m_count = (m_count + 1) % (1 << CW);
        end
        if (flush) begin
            m_valid = 0; m_index = 0;
        end else if (load) begin
            m_valid = (pick >= 0);
            m_index = (pick >= 0) ? pick : 0;
        end
    endtask

    task automatic check_all();
        check("valid", int'(tiv), m_valid);
        check("index", int'(tii), m_index);
        check("alarm", int'(stall_alarm), int'(m_stall == SL));
        check("count", int'(issue_count), m_count);
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_all();
    endtask

    initial begin
        int saved;
        int rr_exp [5] = '{0, 4, 15, 0, 4};

        reset_n = 1'b0; mode = 1'b0; flush = 1'b0; issue_ready = 1'b0; trigger_states = '0;
        mode5 = 1'b1; flush5 = 1'b0; trig5 = '0; rdy5 = 1'b1;
        model_reset();
        #12;
        check("rst_valid", int'(tiv), 0);
        check("rst_index", int'(tii), 0);
        check("rst_alarm", int'(stall_alarm), 0);
        check("rst_count", int'(issue_count), 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Round-robin over slots 0,4,15 starting from pointer 0
        mode = 1'b1; trigger_states = 16'h8011; issue_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("rr_seq", int'(tii), rr_exp[i]);
        end

        // Fixed priority picks slot 4 every cycle
        mode = 1'b0; trigger_states = 16'h0A50;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("fix_idx", int'(tii), 4);
        end

        // Stall on slot 3; triggers are ignored while held
        trigger_states = 16'h0008;
        cycle();
        check("stall_load", int'(tii), 3);
        issue_ready = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            trigger_states = N'($urandom);
            cycle();
            check("stall_idx", int'(tii), 3);
            check("stall_alarm_k", int'(stall_alarm), int'(k >= SL));
        end
        issue_ready = 1'b1; trigger_states = '0;
        cycle();
        check("alarm_clear", int'(stall_alarm), 0);

        // Flush while stalled on slot 7
        trigger_states = 16'h0080;
        cycle();
        issue_ready = 1'b0;
        repeat (3) cycle();
        saved = int'(issue_count);
        flush = 1'b1;
        cycle();
        check("flush_valid", int'(tiv), 0);
        check("flush_count", int'(issue_count), saved);
        flush = 1'b0; issue_ready = 1'b1;
        cycle();
        check("reload7", int'(tii), 7);
        saved = int'(issue_count);
        flush = 1'b1;
        cycle();
        check("flush_acc_count", int'(issue_count), (saved + 1) % (1 << CW));
        flush = 1'b0; mode = 1'b1; trigger_states = 16'h0181;
        cycle();
        check("ptr_after_flush", int'(tii), 8);

        // Empty triggers
        trigger_states = '0;
        cycle();
        saved = int'(issue_count);
        repeat (3) begin
            cycle();
            check("empty_valid", int'(tiv), 0);
            check("empty_count", int'(issue_count), saved);
        end

        // Non-power-of-two instance: pointer wraps from 4 to 0
        trig5 = 5'b10000;
        cycle();
        check("n5_load4", int'(tii5), 4);
        trig5 = 5'b11111;
        cycle();
        check("n5_wrap", int'(tii5), 0);
        cycle();
        check("n5_next", int'(tii5), 1);
        trig5 = '0;

        // Randomized traffic with alternating low-ready phases
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            flush = ($urandom_range(0, 15) == 0);
            if (((i / 40) % 2) == 1) issue_ready = ($urandom_range(0, 9) == 0);
            else                     issue_ready = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 3))
                0:       trigger_states = '0;
                1:       trigger_states = N'(1) << $urandom_range(0, N - 1);
                default: trigger_states = N'($urandom);
            endcase
            cycle();
        end

        // Asynchronous reset mid-stream with a held selection
        flush = 1'b0; issue_ready = 1'b0; trigger_states = 16'h0040; mode = 1'b0;
        cycle();
        cycle();
        #1;
        reset_n = 1'b0;
        #1;
        check("async_valid", int'(tiv), 0);
        check("async_index", int'(tii), 0);
        check("async_alarm", int'(stall_alarm), 0);
        check("async_count", int'(issue_count), 0);
        model_reset();
        #2;
        reset_n = 1'b1;
        mode = 1'b1; trigger_states = 16'hFFFF; issue_ready = 1'b1;
        cycle();
        check("post_rst_first", int'(tii), 0);
        cycle();
        check("post_rst_second", int'(tii), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
